// File: rtl/xbar_post_pkg.sv
// Shared definitions for the crossbar result accumulator: FSM states,
// default parameter values and the signed threshold compare.
package xbar_post_pkg;

  localparam int DEF_NCOL  = 4;
  localparam int DEF_NBITS = 3;
  localparam int DEF_NROWS = 16;
  localparam int DEF_ID_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    EVAL,
    DONE
  } state_t;

  // Both operands arrive sign-extended to 32 bits, so one helper serves any NBITS.
  function automatic logic act_ge(input logic signed [31:0] diff,
                                  input logic signed [31:0] thr);
    return (diff >= thr);
  endfunction

endpackage

// File: rtl/xbar_col_eval.sv
// One column of the accumulator: captures the bit-serial positive and
// negative magnitudes LSB first, then forms their signed difference and
// compares it against the job threshold.
module xbar_col_eval
  import xbar_post_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int CNT_W = 2
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    clear,
  input  logic                    cap_en,
  input  logic [CNT_W-1:0]        bit_cnt,
  input  logic                    pos_bit,
  input  logic                    neg_bit,
  input  logic signed [NBITS:0]   threshold,
  output logic                    act,
  output logic signed [NBITS:0]   diff
);

  logic [NBITS-1:0] pos_acc;
  logic [NBITS-1:0] neg_acc;

  // Each accepted slice lands directly at its bit position, so no shifting is needed.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pos_acc <= '0;
      neg_acc <= '0;
    end else if (clear) begin
      pos_acc <= '0;
      neg_acc <= '0;
    end else if (cap_en) begin
      pos_acc[bit_cnt] <= pos_bit;
      neg_acc[bit_cnt] <= neg_bit;
    end
  end

  // Zero-extended magnitudes give a difference that always fits in NBITS+1 bits.
  always_comb begin
    diff = $signed({1'b0, pos_acc}) - $signed({1'b0, neg_acc});
    act  = act_ge(32'(diff), 32'(threshold));
  end

endmodule

// File: rtl/xbar_result_accum.sv
// Crossbar result accumulator: requests each row of a job from the
// positive/negative crossbar pair, captures the serial column results,
// thresholds the per-column difference and packs one activation bit per
// column into a job-level result vector.
// Optional feature: define XBAR_DIFF_OUT_EN to add the diff_out readback port.
module xbar_result_accum
  import xbar_post_pkg::*;
#(
  parameter int NCOL  = DEF_NCOL,
  parameter int NBITS = DEF_NBITS,
  parameter int NROWS = DEF_NROWS,
  parameter int ID_W  = DEF_ID_W,
  parameter int ROW_W = $clog2(NROWS)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [ID_W-1:0]         start_id,
  input  logic [ROW_W-1:0]        start_last_row,
  input  logic [NBITS:0]          start_threshold,
  output logic                    row_req,
  output logic [ROW_W-1:0]        row_out,
  input  logic                    bit_valid,
  input  logic [NCOL-1:0]         pos_bits,
  input  logic [NCOL-1:0]         neg_bits,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_id,
  output logic [NROWS*NCOL-1:0]   out_data,
  output logic                    busy
`ifdef XBAR_DIFF_OUT_EN
  ,
  output logic [NCOL*(NBITS+1)-1:0] diff_out
`endif
);

  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [ROW_W-1:0] MAX_ROW = ROW_W'(NROWS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  state_t                      state;
  state_t                      next_state;
  logic [ROW_W-1:0]            last_row_q;
  logic signed [NBITS:0]       thr_q;
  logic [CNT_W-1:0]            bit_cnt;
  logic                        capture;
  logic                        clear;
  logic [NCOL-1:0]             act_vec;
  logic [NCOL*(NBITS+1)-1:0]   diff_all;

  // State register; an asynchronous reset abandons any job in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic plus control outputs decoded purely from state and handshakes.
  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    row_req     = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    capture     = 1'b0;
    clear       = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) next_state = REQ;
      end
      REQ: begin
        row_req    = 1'b1;
        clear      = 1'b1;
        next_state = CAP;
      end
      CAP: begin
        if (bit_valid) begin
          capture = 1'b1;
          if (bit_cnt == LAST_BIT) next_state = EVAL;
        end
      end
      EVAL: begin
        next_state = (row_out == last_row_q) ? DONE : REQ;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Job parameters, row/bit counters and the packed activation vector.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_id     <= '0;
      thr_q      <= '0;
      last_row_q <= '0;
      row_out    <= '0;
      bit_cnt    <= '0;
      out_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            out_id     <= start_id;
            thr_q      <= $signed(start_threshold);
            last_row_q <= (start_last_row > MAX_ROW) ? MAX_ROW : start_last_row;
            row_out    <= '0;
            out_data   <= '0;
          end
        end
        REQ: bit_cnt <= '0;
        CAP: if (bit_valid) bit_cnt <= bit_cnt + CNT_W'(1);
        EVAL: begin
          out_data[int'(row_out)*NCOL +: NCOL] <= act_vec;
          if (row_out != last_row_q) row_out <= row_out + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    xbar_col_eval #(
      .NBITS (NBITS),
      .CNT_W (CNT_W)
    ) u_col (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .clear     (clear),
      .cap_en    (capture),
      .bit_cnt   (bit_cnt),
      .pos_bit   (pos_bits[c]),
      .neg_bit   (neg_bits[c]),
      .threshold (thr_q),
      .act       (act_vec[c]),
      .diff      (diff_all[c*(NBITS+1) +: NBITS+1])
    );
  end

`ifdef XBAR_DIFF_OUT_EN
  // Snapshot of the row's signed differences for calibration readback.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)           diff_out <= '0;
    else if (state == EVAL) diff_out <= diff_all;
  end
`else
  logic unused_diff;
  assign unused_diff = ^diff_all;
`endif

endmodule

// File: tb/tb_xbar_result_accum.sv
// Self-checking bench for xbar_result_accum: a crossbar driver streams
// per-row column values, a reference model pushes expected job results to
// a scoreboard queue, and results are popped when out_valid appears.
module tb_xbar_result_accum;

  localparam int NCOL  = 4;
  localparam int NBITS = 3;
  localparam int NROWS = 16;
  localparam int ID_W  = 8;
  localparam int ROW_W = 4;

  typedef struct {
    logic [ID_W-1:0]       id;
    logic [NROWS*NCOL-1:0] data;
  } exp_t;

  logic                  CLK = 1'b0;
  logic                  RESET_N = 1'b0;
  logic                  start_valid = 1'b0;
  logic                  start_ready;
  logic [ID_W-1:0]       start_id = '0;
  logic [ROW_W-1:0]      start_last_row = '0;
  logic [NBITS:0]        start_threshold = '0;
  logic                  row_req;
  logic [ROW_W-1:0]      row_out;
  logic                  bit_valid = 1'b0;
  logic [NCOL-1:0]       pos_bits = '0;
  logic [NCOL-1:0]       neg_bits = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [ID_W-1:0]       out_id;
  logic [NROWS*NCOL-1:0] out_data;
  logic                  busy;
`ifdef XBAR_DIFF_OUT_EN
  logic [NCOL*(NBITS+1)-1:0] diff_out;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pos_v [NROWS][NCOL];
  int   neg_v [NROWS][NCOL];
  exp_t sb [$];

  xbar_result_accum #(
    .NCOL  (NCOL),
    .NBITS (NBITS),
    .NROWS (NROWS),
    .ID_W  (ID_W),
    .ROW_W (ROW_W)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .start_valid     (start_valid),
    .start_ready     (start_ready),
    .start_id        (start_id),
    .start_last_row  (start_last_row),
    .start_threshold (start_threshold),
    .row_req         (row_req),
    .row_out         (row_out),
    .bit_valid       (bit_valid),
    .pos_bits        (pos_bits),
    .neg_bits        (neg_bits),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_id          (out_id),
    .out_data        (out_data),
    .busy            (busy)
`ifdef XBAR_DIFF_OUT_EN
    ,
    .diff_out        (diff_out)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [NROWS*NCOL-1:0] model(input int last, input logic [NBITS:0] thr);
    logic [NROWS*NCOL-1:0] d;
    int t;
    d = '0;
    t = int'($signed(thr));
    for (int r = 0; r <= last; r++)
      for (int c = 0; c < NCOL; c++)
        d[r*NCOL+c] = ((pos_v[r][c] - neg_v[r][c]) >= t);
    return d;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one full job, checks timing and the scoreboard result, then
  // completes the output handshake after 'hold' cycles of back-pressure.
  task automatic run_job(input logic [ID_W-1:0] id, input int last, input logic [NBITS:0] thr,
                         input int gap_row, input bit inject_start, input int hold,
                         input int exp_lat);
    exp_t e;
    exp_t got;
    int   hs;
    int   n;
    bit   ok;
    e.id   = id;
    e.data = model(last, thr);
    start_valid     = 1'b1;
    start_id        = id;
    start_last_row  = ROW_W'(last);
    start_threshold = thr;
    tick();
    start_valid = 1'b0;
    hs = cyc;
    sb.push_back(e);
    for (int r = 0; r <= last; r++) begin
      n = 0;
      while (!row_req && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (row_req !== 1'b1 || row_out !== ROW_W'(r)) begin
        errors++;
        $display("[TB] FAIL row_req row %0d: got req=%b row_out=%0d, want req=1 row_out=%0d",
                 r, row_req, row_out, r);
        return;
      end
      bit_valid = 1'b1;
      pos_bits  = 4'hA;
      neg_bits  = 4'h5;
      if (inject_start && r == 1) begin
        start_valid     = 1'b1;
        start_id        = ~id;
        start_threshold = 4'h8;
      end
      tick();
      start_valid     = 1'b0;
      start_threshold = thr;
      checks++;
      if (row_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL row_req_pulse row %0d: got %b, want 0", r, row_req);
      end
      for (int b = 0; b < NBITS; b++) begin
        if (r == gap_row && b == 1) begin
          for (int g = 0; g < 3; g++) begin
            bit_valid = 1'b0;
            pos_bits  = 4'hF;
            neg_bits  = 4'hF;
            tick();
          end
        end
        bit_valid = 1'b1;
        for (int c = 0; c < NCOL; c++) begin
          pos_bits[c] = 1'((pos_v[r][c] >> b) & 1);
          neg_bits[c] = 1'((neg_v[r][c] >> b) & 1);
        end
        tick();
      end
      bit_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || (cyc - hs) != exp_lat) begin
      errors++;
      $display("[TB] FAIL out_valid_latency: got valid=%b after %0d edges, want valid=1 after %0d",
               out_valid, cyc - hs, exp_lat);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got result id=%h with nothing expected", out_id);
      return;
    end
    got = sb.pop_front();
    if (out_data !== got.data || out_id !== got.id) begin
      errors++;
      $display("[TB] FAIL result: got id=%h data=%h, want id=%h data=%h",
               out_id, out_data, got.id, got.data);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || start_ready !== 1'b0 || out_data !== got.data || out_id !== got.id) begin
        errors++;
        $display("[TB] FAIL hold cycle %0d: got valid=%b ready=%b id=%h data=%h, want valid=1 ready=0 id=%h data=%h",
                 i, out_valid, start_ready, out_id, out_data, got.id, got.data);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL handshake_return: got valid=%b start_ready=%b busy=%b, want 0 1 0",
               out_valid, start_ready, busy);
    end
  endtask

  task automatic fill_all(input int p, input int q);
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOL; c++) begin
        pos_v[r][c] = p;
        neg_v[r][c] = q;
      end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOL; c++) begin
        pos_v[r][c] = 7;
        neg_v[r][c] = (r + c) & 7;
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || row_req !== 1'b0 || out_valid !== 1'b0 ||
        row_out !== '0 || out_id !== '0 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL %s: got ready=%b busy=%b req=%b valid=%b row=%0d id=%h data=%h, want 1 0 0 0 0 00 0",
               tag, start_ready, busy, row_req, out_valid, row_out, out_id, out_data);
    end
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("reset_values");
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_basic();
    fill_all(5, 2);
    run_job(8'h11, 0, 4'h0, -1, 1'b0, 0, 5);
  endtask

  task automatic test_signed_threshold();
    fill_all(1, 3);
    run_job(8'h22, 0, 4'b1110, -1, 1'b0, 0, 5);
    run_job(8'h23, 0, 4'b1111, -1, 1'b0, 0, 5);
  endtask

  task automatic test_full_job();
    fill_ramp();
    run_job(8'h33, 15, 4'h4, -1, 1'b0, 0, 80);
  endtask

  task automatic test_gap();
    fill_ramp();
    run_job(8'h44, 15, 4'h4, 5, 1'b1, 0, 83);
  endtask

  task automatic test_backpressure();
    fill_all(6, 1);
    pos_v[2][3] = 0;
    neg_v[2][3] = 7;
    run_job(8'h55, 3, 4'h3, -1, 1'b0, 10, 20);
  endtask

  task automatic test_back_to_back();
    fill_ramp();
    run_job(8'h61, 1, 4'h2, -1, 1'b0, 0, 10);
    fill_all(2, 6);
    run_job(8'h62, 2, 4'b1100, -1, 1'b0, 0, 15);
  endtask

  task automatic test_async_reset();
    int n;
    fill_ramp();
    start_valid     = 1'b1;
    start_id        = 8'h77;
    start_last_row  = 4'd3;
    start_threshold = 4'h1;
    tick();
    start_valid = 1'b0;
    tick();
    for (int b = 0; b < 2; b++) begin
      bit_valid = 1'b1;
      pos_bits  = 4'hF;
      neg_bits  = 4'h0;
      tick();
    end
    #2;
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    bit_valid = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_output: got %0d cycles of out_valid, want 0", n);
    end
    fill_all(4, 1);
    run_job(8'h78, 1, 4'h3, -1, 1'b0, 0, 10);
  endtask

  initial begin
    $display("[TB] xbar_result_accum bench starting");
    test_reset();
    test_basic();
    test_signed_threshold();
    test_full_job();
    test_gap();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d pending results, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xbar_result_accum.md
# xbar_result_accum

Parametrised successor to the crossbar post-processing stage. For each row of a compute job, it requests the row from the positive/negative crossbar pair and captures their bit-serial column results. It then forms the signed per-column difference and thresholds it into one activation bit per column, packing all rows into a result vector. Job-level valid/ready handshakes sit on both sides, placing it between the crossbar pair and the next layer's input buffer.

## Interface
- NCOL, 4, columns evaluated per row (bits per row in result)
- NBITS, 3, bit-serial result width per column (unsigned magnitude)
- NROWS, 16, maximum rows per job
- ID_W, 8, job id width
- ROW_W, $clog2(NROWS), row index width (derived)

- CLK  in  1  clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- start_valid  in  1  job request
- start_ready  out  1  high only in IDLE
- start_id  in  ID_W  job id, latched on start handshake
- start_last_row  in  ROW_W  index of final row to evaluate
- start_threshold  in  NBITS+1  signed two's-complement threshold
- row_req  out  1  one-cycle pulse: crossbar must stream row row_out
- row_out  out  ROW_W  row currently requested/captured
- bit_valid  in  1  one serial slice present on pos_bits/neg_bits
- pos_bits  in  NCOL  positive-crossbar slice, bit c = column c
- neg_bits  in  NCOL  negative-crossbar slice
- out_valid  out  1  result held until out_ready
- out_ready  in  1  consumer accepts result
- out_id  out  ID_W  id of completed job
- out_data  out  NROWS*NCOL  bit [r*NCOL+c] = activation of row r column c
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, CAP, EVAL, DONE.
- IDLE: start_ready=1. On start_valid: latch id, threshold, and last_row clamped to NROWS-1; clear work vector and row_out; go to REQ.
- REQ: row_req=1 for exactly one cycle; clear bit_cnt; go to CAP.
- CAP: each cycle with bit_valid, store pos_bits[c]/neg_bits[c] into accumulator bit bit_cnt (LSB first) for every column, then bit_cnt++. When bit_valid is high with bit_cnt==NBITS-1, go to EVAL. Cycles without bit_valid stall; there is no timeout.
- EVAL: diff_c = {0,pos_c} - {0,neg_c}, NBITS+1 signed, range ±(2^NBITS-1), no overflow. act_c = (diff_c >= threshold), signed compare. Write act_c into work[row_out*NCOL+c]. If row_out==last_row go to DONE, else increment row_out and go to REQ.
- DONE: out_valid=1, out_data=work, out_id=latched id, all stable. On out_ready go to IDLE. out_data holds its value until the next job's start handshake.
- Rows above last_row read 0 in out_data.
- bit_valid outside CAP is ignored. start_valid outside IDLE is ignored; no queueing.
- Reset values: start_ready=1, all other outputs 0, state IDLE.
- RESET_N asserted mid-job discards all partial state immediately; no out_valid is produced for that job.

## Timing
- Request/acknowledge is combinational-free: all outputs are registered or decoded from state only.
- Per row, with continuous bit_valid: NBITS+2 cycles (REQ 1, CAP NBITS, EVAL 1).
- With continuous bit_valid, out_valid rises (last_row+1)*(NBITS+2) edges after the start handshake edge.
- The first bit_valid is accepted no earlier than the cycle after the row_req pulse.
- out_valid && out_ready on the same edge returns to IDLE. start_ready is high the following cycle, so job throughput loses 1 cycle per job.

## Configuration
- XBAR_DIFF_OUT_EN defined: adds output diff_out, NCOL*(NBITS+1) bits. It is registered in EVAL with that row's signed differences, reset to 0, and holds otherwise. It supports debug and analog-calibration readback.
- XBAR_DIFF_OUT_EN undefined: the port and its registers are absent; behaviour is otherwise identical.

## Structure
- Package xbar_post_pkg holds the state enum, the signed-compare helper function, and default parameter constants.
- Sub-module xbar_col_eval, instantiated NCOL times: serial capture of one column pair plus the subtract/threshold. Inputs are bit_valid gating, bit_cnt, clear, and threshold; output is act plus diff.

## Test plan
- Default params, threshold 0, last_row 0. All columns stream pos=5, neg=2 (LSB first 1,0,1 / 0,1,0) → out_data[3:0]=4'b1111 at edge 5 after handshake, all other bits 0.
- Threshold -2 (4'b1110), pos=1, neg=3, diff=-2 → act=1. Same setup with threshold -1 → act=0. This checks the signed compare.
- last_row=15, row r column c driven with pos=7, neg=(r+c)&7, threshold 4 → bit set iff (r+c)&7 ≤ 3. out_valid at edge 80.
- Insert a 3-cycle bit_valid gap mid-row → results identical to the gap-free run, out_valid delayed by 3. A start_valid pulse during the job is ignored.
- Hold out_ready low 10 cycles in DONE → out_valid/out_data/out_id stable and start_ready low. Assert RESET_N low mid-CAP → all outputs return to reset values asynchronously, and the next job runs cleanly.
